// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (fetch and data), the arbiter and a
// single-port synchronous-read memory.
//   slave  : the arbiter side
//   master : the environment side (requesters plus memory)
interface mem_arbiter_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
);
    // fetch port
    logic                   if_req_valid;
    logic [addrWidth-1:0]   if_req_addr;
    logic                   if_req_ready;
    logic                   if_rsp_valid;
    logic [dataWidth-1:0]   if_rsp_data;

    // data port
    logic                   d_req_valid;
    logic                   d_req_we;
    logic [addrWidth-1:0]   d_req_addr;
    logic [dataWidth-1:0]   d_req_wdata;
    logic [dataWidth/8-1:0] d_req_wmask;
    logic                   d_req_ready;
    logic                   d_rsp_valid;
    logic [dataWidth-1:0]   d_rsp_data;

    // memory command and read data
    logic                   mem_en;
    logic                   mem_we;
    logic [addrWidth-1:0]   mem_addr;
    logic [dataWidth-1:0]   mem_wdata;
    logic [dataWidth/8-1:0] mem_wmask;
    logic [dataWidth-1:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous-read
// memory. One grant per cycle, response exactly one cycle after the grant.
// Arbitration policy:
//   MEM_ARBITER_RR_EN undefined : fixed priority, data wins every conflict
//   MEM_ARBITER_RR_EN defined   : round-robin, the requester not granted
//                                 last wins a conflict
module mem_arbiter #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic          clock,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);
    localparam int MaskWidth = dataWidth / 8;

    // owner tag of the access issued last cycle
    localparam logic [1:0] OWN_NONE    = 2'd0;
    localparam logic [1:0] OWN_FETCH   = 2'd1;
    localparam logic [1:0] OWN_DATA_RD = 2'd2;
    localparam logic [1:0] OWN_DATA_WR = 2'd3;

    logic [1:0]           owner_q, owner_d;
    logic                 grant_if, grant_d;

    logic                 mem_en_c, mem_we_c;
    logic [addrWidth-1:0] mem_addr_c;
    logic [dataWidth-1:0] mem_wdata_c;
    logic [MaskWidth-1:0] mem_wmask_c;
    logic [dataWidth-1:0] if_rsp_data_c, d_rsp_data_c;
    logic                 if_rsp_valid_c, d_rsp_valid_c;

`ifdef MEM_ARBITER_RR_EN
    // prio_data_q = 1 means data wins the next conflict
    logic prio_data_q, prio_data_d;

    // Grant selection: round-robin on conflict, immediate when uncontested.
    // resetn gating keeps readies low while reset is held.
    always_comb begin
        grant_d  = resetn & bus.d_req_valid  & (~bus.if_req_valid | prio_data_q);
        grant_if = resetn & bus.if_req_valid & (~bus.d_req_valid  | ~prio_data_q);
    end

    // Pointer moves to the loser of every grant.
    always_comb begin
        prio_data_d = prio_data_q;
        if (grant_d) begin
            prio_data_d = 1'b0;
        end else if (grant_if) begin
            prio_data_d = 1'b1;
        end
    end

    // Pointer register, data favoured out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prio_data_q <= 1'b1;
        end else begin
            prio_data_q <= prio_data_d;
        end
    end
`else
    // Grant selection: data always beats fetch.
    always_comb begin
        grant_d  = resetn & bus.d_req_valid;
        grant_if = resetn & bus.if_req_valid & ~bus.d_req_valid;
    end
`endif

    // Memory command from the winner; idle cycles drive a quiet bus.
    always_comb begin
        mem_en_c    = grant_if | grant_d;
        mem_we_c    = grant_d & bus.d_req_we;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_wmask_c = '0;
        if (grant_d) begin
            mem_addr_c = bus.d_req_addr;
            if (bus.d_req_we) begin
                mem_wdata_c = bus.d_req_wdata;
                mem_wmask_c = bus.d_req_wmask;
            end
        end else if (grant_if) begin
            mem_addr_c = bus.if_req_addr;
        end
    end

    // Owner tag for the response one cycle later.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant_d) begin
            owner_d = bus.d_req_we ? OWN_DATA_WR : OWN_DATA_RD;
        end else if (grant_if) begin
            owner_d = OWN_FETCH;
        end
    end

    // Owner register; reset drops any in-flight response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response routing from the owner tag.
    always_comb begin
        if_rsp_valid_c = 1'b0;
        if_rsp_data_c  = '0;
        d_rsp_valid_c  = 1'b0;
        d_rsp_data_c   = '0;
        case (owner_q)
            OWN_FETCH: begin
                if_rsp_valid_c = 1'b1;
                if_rsp_data_c  = bus.mem_rdata;
            end
            OWN_DATA_RD: begin
                d_rsp_valid_c = 1'b1;
                d_rsp_data_c  = bus.mem_rdata;
            end
            OWN_DATA_WR: begin
                d_rsp_valid_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.if_req_ready = grant_if;
    assign bus.d_req_ready  = grant_d;
    assign bus.mem_en       = mem_en_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = mem_wdata_c;
    assign bus.mem_wmask    = mem_wmask_c;
    assign bus.if_rsp_valid = if_rsp_valid_c;
    assign bus.if_rsp_data  = if_rsp_data_c;
    assign bus.d_rsp_valid  = d_rsp_valid_c;
    assign bus.d_rsp_data   = d_rsp_data_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/idle/alternating
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    logic clock;
    logic resetn;

    mem_arbiter_if #(.addrWidth(32), .dataWidth(32)) bus ();

    mem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // memory contents are a fixed function of the address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // synchronous-read memory; garbage when no read was issued
    always @(posedge clock) begin
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= mem_f(bus.mem_addr);
        else
            bus.mem_rdata <= 32'hBAD0_0BAD;
    end

    // model state: what response is due next cycle, and who was granted last
    bit          m_if_pend;
    bit          m_d_pend;
    logic [31:0] m_data;
    bit          m_last_data;

    task automatic model_reset();
        m_if_pend   = 1'b0;
        m_d_pend    = 1'b0;
        m_data      = '0;
        m_last_data = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: called at posedge+1, drives, checks at negedge, returns at next posedge+1.
    task automatic step(input bit fv, input logic [31:0] fa,
                        input bit dv, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dm,
                        output bit fg, output bit dg);
        bit exp_d, exp_f;
        bus.if_req_valid = fv;
        bus.if_req_addr  = fa;
        bus.d_req_valid  = dv;
        bus.d_req_we     = dwe;
        bus.d_req_addr   = da;
        bus.d_req_wdata  = dwd;
        bus.d_req_wmask  = dm;
        @(negedge clock);
`ifdef MEM_ARBITER_RR_EN
        exp_d = dv && (!fv || !m_last_data);
`else
        exp_d = dv;
`endif
        exp_f = fv && !exp_d;
        chk("if_req_ready", bus.if_req_ready, exp_f);
        chk("d_req_ready",  bus.d_req_ready,  exp_d);
        chk("mem_en",       bus.mem_en,       exp_f || exp_d);
        chk("mem_we",       bus.mem_we,       exp_d && dwe);
        chk("mem_wmask",    bus.mem_wmask,    (exp_d && dwe) ? dm : 4'h0);
        if (exp_f || exp_d)
            chk("mem_addr", bus.mem_addr, exp_d ? da : fa);
        if (exp_d && dwe)
            chk("mem_wdata", bus.mem_wdata, dwd);
        chk("if_rsp_valid", bus.if_rsp_valid, m_if_pend);
        chk("d_rsp_valid",  bus.d_rsp_valid,  m_d_pend);
        if (m_if_pend)
            chk("if_rsp_data", bus.if_rsp_data, m_data);
        if (m_d_pend)
            chk("d_rsp_data", bus.d_rsp_data, m_data);
        m_if_pend = exp_f;
        m_d_pend  = exp_d;
        m_data    = exp_f ? mem_f(fa) : ((exp_d && !dwe) ? mem_f(da) : 32'h0);
        if (exp_f || exp_d)
            m_last_data = exp_d;
        fg = exp_f;
        dg = exp_d;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] fa;
        bit          dv;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dm;
        bit          if_rdy;
        bit          d_rdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fg, dg;
        bit          f_hold, d_hold;
        logic [31:0] r_fa, r_da, r_dwd;
        bit          r_dwe;
        logic [3:0]  r_dm;
        bit          r_fv, r_dv;

        // fetch after reset, then four conflicts, a write, idle, singles
        tbl[0] = '{1, 32'h100,  0, 0, 32'h0,    32'h0,         4'h0, 1, 0};
        tbl[1] = '{1, 32'h104,  1, 0, 32'h40,   32'h0,         4'h0, 0, 1};
`ifdef MEM_ARBITER_RR_EN
        tbl[2] = '{1, 32'h104,  1, 0, 32'h44,   32'h0,         4'h0, 1, 0};
        tbl[3] = '{1, 32'h104,  1, 0, 32'h44,   32'h0,         4'h0, 0, 1};
        tbl[4] = '{1, 32'h104,  1, 0, 32'h48,   32'h0,         4'h0, 1, 0};
`else
        tbl[2] = '{1, 32'h104,  1, 0, 32'h44,   32'h0,         4'h0, 0, 1};
        tbl[3] = '{1, 32'h104,  1, 0, 32'h48,   32'h0,         4'h0, 0, 1};
        tbl[4] = '{1, 32'h104,  1, 0, 32'h4C,   32'h0,         4'h0, 0, 1};
`endif
        tbl[5] = '{0, 32'h0,    1, 1, 32'h2000, 32'hDEADBEEF,  4'hF, 0, 1};
        tbl[6] = '{0, 32'h0,    0, 0, 32'h0,    32'h0,         4'h0, 0, 0};
        tbl[7] = '{0, 32'h0,    1, 0, 32'h80,   32'h0,         4'h0, 0, 1};
        tbl[8] = '{1, 32'h200,  0, 0, 32'h0,    32'h0,         4'h0, 1, 0};
        tbl[9] = '{0, 32'h0,    0, 0, 32'h0,    32'h0,         4'h0, 0, 0};

        // reset held with both valids high: everything quiet
        resetn           = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h100;
        bus.d_req_valid  = 1'b1;
        bus.d_req_we     = 1'b1;
        bus.d_req_addr   = 32'h2000;
        bus.d_req_wdata  = 32'h1234_5678;
        bus.d_req_wmask  = 4'hF;
        model_reset();
        @(negedge clock);
        chk("rst if_req_ready", bus.if_req_ready, 1'b0);
        chk("rst d_req_ready",  bus.d_req_ready,  1'b0);
        chk("rst mem_en",       bus.mem_en,       1'b0);
        chk("rst mem_we",       bus.mem_we,       1'b0);
        chk("rst if_rsp_valid", bus.if_rsp_valid, 1'b0);
        chk("rst d_rsp_valid",  bus.d_rsp_valid,  1'b0);
        chk("rst if_rsp_data",  bus.if_rsp_data,  32'h0);
        chk("rst d_rsp_data",   bus.d_rsp_data,   32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].fv, tbl[i].fa, tbl[i].dv, tbl[i].dwe, tbl[i].da,
                 tbl[i].dwd, tbl[i].dm, fg, dg);
            chk($sformatf("tbl[%0d] if_grant", i), fg, tbl[i].if_rdy);
            chk($sformatf("tbl[%0d] d_grant", i),  dg, tbl[i].d_rdy);
        end

        // alternating fetch / data read
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step(1, 32'h400 + 32'(i * 4), 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);
            else
                step(0, 32'h0, 1, 0, 32'h800 + 32'(i * 4), 32'h0, 4'h0, fg, dg);
        end
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);

        // reset in the cycle after a fetch grant discards the response
        step(1, 32'h300, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);
        resetn           = 1'b0;
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        @(negedge clock);
        chk("rstmid if_rsp_valid", bus.if_rsp_valid, 1'b0);
        chk("rstmid d_rsp_valid",  bus.d_rsp_valid,  1'b0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);
        step(1, 32'h304, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);

        // ten idle cycles
        for (int i = 0; i < 10; i++)
            step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);

        // randomized requesters that hold their request until granted
        f_hold = 1'b0;
        d_hold = 1'b0;
        r_fv = 0; r_dv = 0; r_fa = 0; r_da = 0; r_dwd = 0; r_dwe = 0; r_dm = 0;
        for (int i = 0; i < 400; i++) begin
            if (!f_hold) begin
                r_fv = ($urandom_range(0, 99) < 60);
                r_fa = $urandom;
                f_hold = r_fv;
            end
            if (!d_hold) begin
                r_dv  = ($urandom_range(0, 99) < 50);
                r_dwe = $urandom_range(0, 1);
                r_da  = $urandom;
                r_dwd = $urandom;
                r_dm  = 4'($urandom_range(0, 15));
                d_hold = r_dv;
            end
            step(r_fv, r_fa, r_dv, r_dwe, r_da, r_dwd, r_dm, fg, dg);
            if (fg) begin
                f_hold = 1'b0;
                r_fv   = 1'b0;
            end
            if (dg) begin
                d_hold = 1'b0;
                r_dv   = 1'b0;
            end
        end
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, fg, dg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
